alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Registered output stage that consumes each 32-bit result produced by the ALU bit-slice datapath (AND/OR/XOR/ADD slices) and holds it for the multicycle CPU control unit. It buffers up to two results in a skid buffer with valid/ready handshakes on both sides. It derives zero/negative status flags at capture time. Its output drives the ALUOut register path and the branch-compare logic.

## Interface
- WIDTH, 32, result width in bits; the buffer depth is fixed at 2 entries.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- in_valid  input  1  ALU result on in_result is valid this cycle
- in_result  input  WIDTH  ALU result word
- in_carry  input  1  carry-out from ALU adder slice (don't-care for logic ops)
- in_overflow  input  1  signed overflow from ALU adder slice
- in_ready  output  1  stage can accept a result this cycle
- out_valid  output  1  out_* fields hold a valid buffered result
- out_ready  input  1  consumer accepts the head result this cycle
- out_result  output  WIDTH  head result word
- out_carry  output  1  head carry flag
- out_overflow  output  1  head overflow flag
- out_zero  output  1  head result == 0
- out_negative  output  1  head result[WIDTH-1]

## Operation
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- Occupancy states:
  - EMPTY (0 entries): out_valid=0, in_ready=1.
  - ONE (1 entry): out_valid=1, in_ready=1.
  - FULL (2 entries): out_valid=1, in_ready=0.
- Transitions:
  - EMPTY + push -> ONE.
  - ONE + push only -> FULL.
  - ONE + pop only -> EMPTY.
  - ONE + push & pop -> ONE, with the new word becoming head.
  - FULL + pop -> ONE, with the tail entry moving to head.
- Pushes while FULL cannot occur because in_ready=0. in_valid with in_ready=0 is ignored; the upstream must hold its data.
- Each entry stores result, carry, overflow, zero and negative.
- zero = NOR-reduction of in_result, computed on push, never recomputed at output.
- negative = in_result[WIDTH-1] on push.
- Ordering is strict FIFO; no entry is ever dropped or duplicated.
- out_* fields are stable while out_valid=1 and out_ready=0.
- in_ready and out_valid are functions of registered state only; there is no combinational path from out_ready to in_ready, or from in_valid to out_valid.

## Timing
- Latency: a word pushed in cycle N, while in EMPTY, appears with out_valid=1 in cycle N+1.
- Throughput: 1 word/cycle sustained when out_ready is held high.
- Reset, when reset=1 at a rising edge:
  - State -> EMPTY.
  - out_valid=0.
  - out_result, out_carry, out_overflow and out_negative = 0; out_zero = 0.
- in_ready is forced to 0 while reset is high, and is 1 in the first cycle after reset deasserts.
- Reset mid-operation discards all buffered entries. Pushes and pops in the reset cycle have no effect.
- Buffered data registers are not cleared on pop. Their value is don't-care while out_valid=0, except that the reset values above hold until the first push.

## Configuration
- ALU_RESULT_FLAGS_EN defined:
  - zero/negative are computed on push, stored per entry, and driven on out_zero/out_negative.
- ALU_RESULT_FLAGS_EN undefined:
  - No flag logic or flag storage is built.
  - out_zero and out_negative are tied to 0.
  - Entries store only result, carry and overflow.
- All ports exist in both builds; carry/overflow passthrough is always present.

## Test plan
- Reset then single push: in_result=32'h0000_0000, in_valid=1 at cycle 1 -> cycle 2: out_valid=1, out_result=0, out_zero=1 (0 if flags disabled), out_negative=0.
- Fill with out_ready=0: push 32'hFFFF_0000 then 32'h0000_00FF -> FULL, in_ready=0. Head is FFFF_0000 with out_negative=1. Third in_valid is ignored.
- Drain from FULL: out_ready=1 for 2 cycles -> outputs FFFF_0000 then 0000_00FF, then out_valid=0 and in_ready=1.
- Simultaneous push/pop in ONE: head A=32'h1234_5678, push B=32'h8000_0000 with out_ready=1 -> next cycle head=B, out_negative=1, state ONE.
- Streaming: 8 consecutive pushes of 0..7 with out_ready=1 -> 8 outputs 0..7 on consecutive cycles. in_ready stays 1 throughout, and only value 0 has out_zero=1.
- Reset mid-operation: FULL state, assert reset 1 cycle -> out_valid=0, out_result=0, in_ready=0 in the reset cycle and 1 in the next; prior entries are never output.

Source files
------------

// File: rtl/alu_result_stage.sv
// Two-entry skid buffer holding ALU results (plus carry/overflow and optional zero/negative flags) for the control unit.
// Optional feature: define ALU_RESULT_FLAGS_EN to build zero/negative flag capture and storage.
module alu_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic             in_overflow,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_negative
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             overflow;
`ifdef ALU_RESULT_FLAGS_EN
        logic             zero;
        logic             negative;
`endif
    } entry_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    logic   out_valid_q, out_valid_d;
    logic   full_q, full_d;
    entry_t in_entry;
    logic   push, pop;

    // Handshake outputs come from registered state; reset gates in_ready directly.
    assign in_ready  = !full_q && !reset;
    assign out_valid = out_valid_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid_q && out_ready;

    always_comb begin
        in_entry          = '0;
        in_entry.result   = in_result;
        in_entry.carry    = in_carry;
        in_entry.overflow = in_overflow;
`ifdef ALU_RESULT_FLAGS_EN
        in_entry.zero     = ~|in_result;
        in_entry.negative = in_result[WIDTH-1];
`endif
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = in_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b10: begin
                        tail_d  = in_entry;
                        state_d = FULL;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: head_d = in_entry;
                    default: ;
                endcase
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        out_valid_d = (state_d != EMPTY);
        full_d      = (state_d == FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            out_valid_q <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            out_valid_q <= out_valid_d;
            full_q      <= full_d;
        end
    end

    assign out_result   = head_q.result;
    assign out_carry    = head_q.carry;
    assign out_overflow = head_q.overflow;
`ifdef ALU_RESULT_FLAGS_EN
    assign out_zero     = head_q.zero;
    assign out_negative = head_q.negative;
`else
    assign out_zero     = 1'b0;
    assign out_negative = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed-vector bench for alu_result_stage; flag expectations follow ALU_RESULT_FLAGS_EN.
module tb_alu_result_stage;

`ifdef ALU_RESULT_FLAGS_EN
    localparam logic FLAGS = 1'b1;
`else
    localparam logic FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_result;
    logic        in_carry;
    logic        in_overflow;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_carry;
    logic        out_overflow;
    logic        out_zero;
    logic        out_negative;

    int n_chk  = 0;
    int n_pass = 0;

    alu_result_stage #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_result    (in_result),
        .in_carry     (in_carry),
        .in_overflow  (in_overflow),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_negative (out_negative)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance one edge, then let outputs settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_result = '0;
        in_carry = 1'b0; in_overflow = 1'b0; out_ready = 1'b0;
        step(); step();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_flags", {28'd0, out_carry, out_overflow, out_zero, out_negative}, 32'd0);
        reset = 1'b0; #1;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // single push of zero
        in_valid = 1'b1; in_result = 32'h0; in_carry = 1'b1; in_overflow = 1'b0;
        step();
        in_valid = 1'b0; in_carry = 1'b0;
        check("one_valid", {31'd0, out_valid}, 32'd1);
        check("one_result", out_result, 32'h0);
        check("one_zero", {31'd0, out_zero}, {31'd0, FLAGS});
        check("one_neg", {31'd0, out_negative}, 32'd0);
        check("one_carry", {31'd0, out_carry}, 32'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("pop_empty", {31'd0, out_valid}, 32'd0);

        // fill, blocked third push, drain
        in_valid = 1'b1; in_result = 32'hFFFF_0000; in_overflow = 1'b1; step();
        in_result = 32'h0000_00FF; in_overflow = 1'b0; step();
        check("full_ready", {31'd0, in_ready}, 32'd0);
        check("full_head", out_result, 32'hFFFF_0000);
        check("full_neg", {31'd0, out_negative}, {31'd0, FLAGS});
        check("full_ovf", {31'd0, out_overflow}, 32'd1);
        in_result = 32'hDEAD_BEEF; step();
        in_valid = 1'b0;
        check("blocked_head", out_result, 32'hFFFF_0000);
        check("blocked_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1; step();
        check("drain1_result", out_result, 32'h0000_00FF);
        check("drain1_valid", {31'd0, out_valid}, 32'd1);
        check("drain1_ready", {31'd0, in_ready}, 32'd1);
        check("drain1_neg", {31'd0, out_negative}, 32'd0);
        step(); out_ready = 1'b0;
        check("drain2_valid", {31'd0, out_valid}, 32'd0);
        check("drain2_ready", {31'd0, in_ready}, 32'd1);

        // push and pop together while holding one entry
        in_valid = 1'b1; in_result = 32'h1234_5678; step();
        check("a_head", out_result, 32'h1234_5678);
        in_result = 32'h8000_0000; out_ready = 1'b1; step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("b_head", out_result, 32'h8000_0000);
        check("b_neg", {31'd0, out_negative}, {31'd0, FLAGS});
        check("b_valid", {31'd0, out_valid}, 32'd1);
        check("b_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("b_pop", {31'd0, out_valid}, 32'd0);

        // streaming 0..7
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_result = 32'(i); step();
            check($sformatf("strm%0d_result", i), out_result, 32'(i));
            check($sformatf("strm%0d_zero", i), {31'd0, out_zero}, {31'd0, FLAGS && (i == 0)});
            check($sformatf("strm%0d_ready", i), {30'd0, out_valid, in_ready}, 32'd3);
        end
        in_valid = 1'b0; step(); out_ready = 1'b0;
        check("strm_end", {31'd0, out_valid}, 32'd0);

        // reset while full
        in_valid = 1'b1; in_result = 32'hAAAA_0001; step();
        in_result = 32'hAAAA_0002; step();
        check("pre_rst_full", {31'd0, in_ready}, 32'd0);
        reset = 1'b1; in_result = 32'hAAAA_0003; out_ready = 1'b1; #1;
        check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        step();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", out_result, 32'd0);
        check("mid_rst_ready_after", {31'd0, in_ready}, 32'd1);
        step();
        check("mid_rst_idle", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1; in_result = 32'h0000_0055; step();
        in_valid = 1'b0;
        check("post_rst_head", out_result, 32'h0000_0055);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("post_rst_drain", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
